// File: rtl/beta_trap_sequencer_if.sv
// beta_trap_sequencer_if
// Bundle between the trap sequencer, the datapath/CSR file and fetch redirect.
// The sequencer is the "master": it raises flush/commit/redirect requests and
// owns the trap CSR values; the pipeline side is the "slave".
interface beta_trap_sequencer_if #(
   parameter int DataWidth   = 32,
   parameter int NumLocalIrq = 16
);
   // Trap sources and architectural context from the datapath / CSR file
   logic                   priv_lvl_i;
   logic [DataWidth-1:0]   fault_pc_i;
   logic [DataWidth-1:0]   next_pc_i;
   logic [DataWidth-1:0]   fault_instr_i;
   logic [DataWidth-1:0]   fault_addr_i;
   logic [1:0]             instr_exc_i;
   logic [1:0]             lsu_exc_i;
   logic                   ecall_i;
   logic                   mret_i;
   logic                   mstatus_mie_i;
   logic                   mstatus_mpie_i;
   logic [DataWidth-1:0]   mie_i;
   logic [DataWidth-1:0]   mtvec_i;
   logic [DataWidth-1:0]   mepc_i;
   logic                   sw_irq_i;
   logic                   tim_irq_i;
   logic                   ext_irq_i;
   logic [NumLocalIrq-1:0] local_irq_i;
   // Pipeline handshake acknowledgements
   logic                   flush_ack_i;
   logic                   redirect_ack_i;
   // Sequencer outputs
   logic [DataWidth-1:0]   mip_o;
   logic                   flush_req_o;
   logic                   csr_we_o;
   logic [DataWidth-1:0]   mcause_o;
   logic [DataWidth-1:0]   mepc_o;
   logic [DataWidth-1:0]   mtval_o;
   logic [2:0]             trap_state_o;
   logic                   trap_valid_o;
   logic [DataWidth-1:0]   trap_address_o;
   logic                   busy_o;

   modport master (
      input  priv_lvl_i, fault_pc_i, next_pc_i, fault_instr_i, fault_addr_i,
             instr_exc_i, lsu_exc_i, ecall_i, mret_i, mstatus_mie_i,
             mstatus_mpie_i, mie_i, mtvec_i, mepc_i, sw_irq_i, tim_irq_i,
             ext_irq_i, local_irq_i, flush_ack_i, redirect_ack_i,
      output mip_o, flush_req_o, csr_we_o, mcause_o, mepc_o, mtval_o,
             trap_state_o, trap_valid_o, trap_address_o, busy_o
   );

   modport slave (
      output priv_lvl_i, fault_pc_i, next_pc_i, fault_instr_i, fault_addr_i,
             instr_exc_i, lsu_exc_i, ecall_i, mret_i, mstatus_mie_i,
             mstatus_mpie_i, mie_i, mtvec_i, mepc_i, sw_irq_i, tim_irq_i,
             ext_irq_i, local_irq_i, flush_ack_i, redirect_ack_i,
      input  mip_o, flush_req_o, csr_we_o, mcause_o, mepc_o, mtval_o,
             trap_state_o, trap_valid_o, trap_address_o, busy_o
   );
endinterface

// File: rtl/beta_trap_sequencer.sv
// beta_trap_sequencer
// Sequential trap controller: arbitrates exceptions, MRET and interrupts,
// captures mcause/mepc/mtval on the take edge and then walks the pipeline
// through flush -> CSR update -> redirect. One trap in flight at a time.
// Optional feature macro: BETA_TCU_NMI_EN adds the nmi_i port and a sticky,
// edge-triggered non-maskable interrupt that outranks everything else.
module beta_trap_sequencer #(
   parameter int                   DataWidth   = 32,
   parameter int                   NumLocalIrq = 16,
   parameter logic [DataWidth-1:0] NmiVector   = '0
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
`ifdef BETA_TCU_NMI_EN
   input  logic                  nmi_i,
`endif
   beta_trap_sequencer_if.master bus
);
   // Cause codes never exceed DataWidth-1, so this many bits hold any code
   localparam int CodeW = $clog2(DataWidth);

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_UPDATE, ST_REDIRECT} state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] mip_q, mip_d;
   logic [DataWidth-1:0] mcause_q, mcause_d;
   logic [DataWidth-1:0] mepc_q, mepc_d;
   logic [DataWidth-1:0] mtval_q, mtval_d;
   logic [DataWidth-1:0] target_q, target_d;
   logic [2:0]           tstate_q, tstate_d;

   logic [DataWidth-1:0] base;
   logic [DataWidth-1:0] irq_pend;
   logic                 irq_take;
   logic [CodeW-1:0]     irq_code;
   logic                 exc_valid;
   logic [CodeW-1:0]     exc_code;
   logic [DataWidth-1:0] exc_tval;
   logic                 nmi_req;
   logic                 nmi_take;
   logic                 unused_bits;

   assign base        = {bus.mtvec_i[DataWidth-1:2], 2'b00};
   assign unused_bits = &{1'b0, bus.mtvec_i[1]};

   // Map level interrupt inputs onto their mip bit positions; all others read 0
   for (genvar gi = 0; gi < DataWidth; gi++) begin : g_mip
      if (gi == 3) begin : g_sw
         assign mip_d[gi] = bus.sw_irq_i;
      end else if (gi == 7) begin : g_tim
         assign mip_d[gi] = bus.tim_irq_i;
      end else if (gi == 11) begin : g_ext
         assign mip_d[gi] = bus.ext_irq_i;
      end else if (gi >= 16 && gi < 16 + NumLocalIrq) begin : g_loc
         assign mip_d[gi] = bus.local_irq_i[gi-16];
      end else begin : g_zero
         assign mip_d[gi] = 1'b0;
      end
   end

`ifdef BETA_TCU_NMI_EN
   logic nmi_prev_q;
   logic nmi_pend_q;
   logic nmi_rise;

   assign nmi_rise = nmi_i & ~nmi_prev_q;
   // A fresh edge in the take cycle counts, so NMI beats a same-cycle exception
   assign nmi_req  = nmi_pend_q | nmi_rise;

   // Sticky NMI flag: set on a rising edge (also while busy), cleared when taken
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
      end else begin
         nmi_prev_q <= nmi_i;
         if (nmi_take)
            nmi_pend_q <= 1'b0;
         else if (nmi_rise)
            nmi_pend_q <= 1'b1;
      end
   end
`else
   assign nmi_req = 1'b0;
`endif

   assign nmi_take = (state_q == ST_IDLE) & nmi_req;

   // Interrupt arbitration on the registered pending bits: ext > tim > sw > local[0..N-1]
   always_comb begin
      irq_pend = mip_q & bus.mie_i;
      irq_code = '0;
      for (int i = NumLocalIrq - 1; i >= 0; i--) begin
         if (irq_pend[16+i]) irq_code = CodeW'(16 + i);
      end
      if (irq_pend[3])  irq_code = CodeW'(3);
      if (irq_pend[7])  irq_code = CodeW'(7);
      if (irq_pend[11]) irq_code = CodeW'(11);
      irq_take = bus.mstatus_mie_i & (|irq_pend);
   end

   // Synchronous exception priority and the matching mtval source
   always_comb begin
      exc_valid = 1'b1;
      exc_code  = '0;
      exc_tval  = '0;
      if (bus.instr_exc_i[1]) begin
         exc_code = CodeW'(2);
         exc_tval = bus.fault_instr_i;
      end else if (bus.instr_exc_i[0]) begin
         exc_code = CodeW'(0);
         exc_tval = bus.fault_instr_i;
      end else if (bus.lsu_exc_i[0]) begin
         exc_code = CodeW'(4);
         exc_tval = bus.fault_addr_i;
      end else if (bus.lsu_exc_i[1]) begin
         exc_code = CodeW'(6);
         exc_tval = bus.fault_addr_i;
      end else if (bus.ecall_i) begin
         exc_code = bus.priv_lvl_i ? CodeW'(11) : CodeW'(8);
      end else begin
         exc_valid = 1'b0;
      end
   end

   // Next-state logic and take-edge capture of the trap context
   always_comb begin
      state_d  = state_q;
      mcause_d = mcause_q;
      mepc_d   = mepc_q;
      mtval_d  = mtval_q;
      target_d = target_q;
      tstate_d = tstate_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FLUSH;
            if (nmi_take) begin
               mcause_d = {1'b1, {(DataWidth-1){1'b0}}};
               mepc_d   = bus.next_pc_i;
               mtval_d  = '0;
               tstate_d = {1'b0, bus.mstatus_mie_i, bus.priv_lvl_i};
               target_d = NmiVector;
            end else if (exc_valid) begin
               mcause_d = DataWidth'(exc_code);
               mepc_d   = bus.fault_pc_i;
               mtval_d  = exc_tval;
               tstate_d = {1'b0, bus.mstatus_mie_i, bus.priv_lvl_i};
               target_d = base;
            end else if (bus.mret_i) begin
               tstate_d = {bus.mstatus_mpie_i, 1'b1, 1'b0};
               target_d = bus.mepc_i;
            end else if (irq_take) begin
               mcause_d = {1'b1, (DataWidth-1)'(irq_code)};
               mepc_d   = bus.next_pc_i;
               mtval_d  = '0;
               tstate_d = {1'b0, bus.mstatus_mie_i, bus.priv_lvl_i};
               target_d = bus.mtvec_i[0] ? base + DataWidth'({irq_code, 2'b00}) : base;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH:    if (bus.flush_ack_i) state_d = ST_UPDATE;
         ST_UPDATE:   state_d = ST_REDIRECT;
         ST_REDIRECT: if (bus.redirect_ack_i) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Pending-bit snapshot and captured trap context
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         mip_q    <= '0;
         mcause_q <= '0;
         mepc_q   <= '0;
         mtval_q  <= '0;
         target_q <= '0;
         tstate_q <= '0;
      end else begin
         mip_q    <= mip_d;
         mcause_q <= mcause_d;
         mepc_q   <= mepc_d;
         mtval_q  <= mtval_d;
         target_q <= target_d;
         tstate_q <= tstate_d;
      end
   end

   // Handshake strobes are masked by reset so an abort never commits CSRs
   assign bus.flush_req_o    = (state_q == ST_FLUSH) & rstn_i;
   assign bus.csr_we_o       = (state_q == ST_UPDATE) & rstn_i;
   assign bus.trap_valid_o   = (state_q == ST_REDIRECT) & rstn_i;
   assign bus.busy_o         = (state_q != ST_IDLE);
   assign bus.mip_o          = mip_q;
   assign bus.mcause_o       = mcause_q;
   assign bus.mepc_o         = mepc_q;
   assign bus.mtval_o        = mtval_q;
   assign bus.trap_state_o   = tstate_q;
   assign bus.trap_address_o = target_q;
endmodule

// File: tb/tb_beta_trap_sequencer.sv
// Testbench for beta_trap_sequencer: directed scenarios plus randomized traps
// checked against a priority-table reference model.
module tb_beta_trap_sequencer;
   localparam int          DW      = 32;
   localparam int          NL      = 16;
   localparam logic [31:0] NMI_VEC = 32'h0000_0F00;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad   = 0;

   typedef struct packed {
      logic        is_mret;
      logic        take;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] tval;
      logic [31:0] target;
      logic [2:0]  st;
   } trap_t;

   beta_trap_sequencer_if #(.DataWidth(DW), .NumLocalIrq(NL)) bus ();
`ifdef BETA_TCU_NMI_EN
   logic nmi = 1'b0;
`endif

   beta_trap_sequencer #(.DataWidth(DW), .NumLocalIrq(NL), .NmiVector(NMI_VEC)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
`ifdef BETA_TCU_NMI_EN
      .nmi_i  (nmi),
`endif
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_mip(logic sw, logic tim, logic ext, logic [NL-1:0] loc);
      return (32'(sw) << 3) | (32'(tim) << 7) | (32'(ext) << 11) | (32'(loc) << 16);
   endfunction

   // Reference: what should be taken given the current inputs (irqs held >= 1 cycle)
   function automatic trap_t model_take();
      trap_t       t;
      logic [31:0] base, pend;
      int          src;
      t       = '0;
      base    = bus.mtvec_i & 32'hFFFF_FFFC;
      pend    = exp_mip(bus.sw_irq_i, bus.tim_irq_i, bus.ext_irq_i, bus.local_irq_i) & bus.mie_i;
      t.take  = 1'b1;
      t.st    = {1'b0, bus.mstatus_mie_i, bus.priv_lvl_i};
      t.target = base;
      t.epc   = bus.fault_pc_i;
      if (bus.instr_exc_i[1]) begin
         t.cause = 2; t.tval = bus.fault_instr_i;
      end else if (bus.instr_exc_i[0]) begin
         t.cause = 0; t.tval = bus.fault_instr_i;
      end else if (bus.lsu_exc_i[0]) begin
         t.cause = 4; t.tval = bus.fault_addr_i;
      end else if (bus.lsu_exc_i[1]) begin
         t.cause = 6; t.tval = bus.fault_addr_i;
      end else if (bus.ecall_i) begin
         t.cause = bus.priv_lvl_i ? 32'd11 : 32'd8;
      end else if (bus.mret_i) begin
         t.is_mret = 1'b1;
         t.st      = {bus.mstatus_mpie_i, 2'b10};
         t.target  = bus.mepc_i;
      end else begin
         src = -1;
         for (int k = 0; k < 3 + NL; k++) begin
            int s;
            s = (k == 0) ? 11 : (k == 1) ? 7 : (k == 2) ? 3 : 16 + k - 3;
            if (src < 0 && pend[s]) src = s;
         end
         if (bus.mstatus_mie_i && src >= 0) begin
            t.cause = 32'h8000_0000 | 32'(src);
            t.epc   = bus.next_pc_i;
            if (bus.mtvec_i[0]) t.target = base + 32'(4 * src);
         end else begin
            t.take = 1'b0;
         end
      end
      return t;
   endfunction

   task automatic clear_exc();
      bus.instr_exc_i = 2'b00;
      bus.lsu_exc_i   = 2'b00;
      bus.ecall_i     = 1'b0;
      bus.mret_i      = 1'b0;
   endtask

   // Called at posedge+1 in IDLE with inputs that cause a take on the next edge
   task automatic take_and_check(input trap_t e, input int nf, input int nr,
                                 input bit noise, input bit nmi_busy, input string nm);
      @(negedge clk);
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL %s idle_before_take busy=%0b exp=0", nm, bus.busy_o); end
      @(posedge clk); #1;
      clear_exc();
`ifdef BETA_TCU_NMI_EN
      nmi = 1'b0;
`endif
      for (int i = 1; i <= nf; i++) begin
         if (i == nf) bus.flush_ack_i = 1'b1;
         if (noise) begin
            bus.instr_exc_i = 2'($urandom); bus.lsu_exc_i = 2'($urandom);
            bus.ecall_i = 1'($urandom); bus.mret_i = 1'($urandom);
         end
         if (nmi_busy && i == 1) begin
`ifdef BETA_TCU_NMI_EN
            nmi = 1'b1;
`endif
         end
         @(negedge clk);
         total++; if (bus.flush_req_o !== 1'b1) begin bad++; $display("FAIL %s flush_req cyc%0d got=%0b exp=1", nm, i, bus.flush_req_o); end
         total++; if (bus.csr_we_o !== 1'b0) begin bad++; $display("FAIL %s csr_we_in_flush got=%0b exp=0", nm, bus.csr_we_o); end
         @(posedge clk); #1;
         bus.flush_ack_i = 1'b0;
`ifdef BETA_TCU_NMI_EN
         nmi = 1'b0;
`endif
      end
      @(negedge clk);
      total++; if (bus.csr_we_o !== 1'b1) begin bad++; $display("FAIL %s csr_we got=%0b exp=1", nm, bus.csr_we_o); end
      total++; if (bus.flush_req_o !== 1'b0) begin bad++; $display("FAIL %s flush_req_in_update got=%0b exp=0", nm, bus.flush_req_o); end
      total++; if (bus.trap_state_o !== e.st) begin bad++; $display("FAIL %s trap_state got=%b exp=%b", nm, bus.trap_state_o, e.st); end
      if (!e.is_mret) begin
         total++; if (bus.mcause_o !== e.cause) begin bad++; $display("FAIL %s mcause got=%08h exp=%08h", nm, bus.mcause_o, e.cause); end
         total++; if (bus.mepc_o !== e.epc) begin bad++; $display("FAIL %s mepc got=%08h exp=%08h", nm, bus.mepc_o, e.epc); end
         total++; if (bus.mtval_o !== e.tval) begin bad++; $display("FAIL %s mtval got=%08h exp=%08h", nm, bus.mtval_o, e.tval); end
      end
      @(posedge clk); #1;
      for (int j = 1; j <= nr; j++) begin
         if (j == nr) begin
            bus.redirect_ack_i = 1'b1;
            clear_exc();
         end else if (noise) begin
            bus.instr_exc_i = 2'($urandom); bus.mret_i = 1'($urandom);
            bus.mtvec_i = $urandom; bus.mepc_i = $urandom;
         end
         @(negedge clk);
         total++; if (bus.trap_valid_o !== 1'b1) begin bad++; $display("FAIL %s trap_valid cyc%0d got=%0b exp=1", nm, j, bus.trap_valid_o); end
         total++; if (bus.trap_address_o !== e.target) begin bad++; $display("FAIL %s target got=%08h exp=%08h", nm, bus.trap_address_o, e.target); end
         total++; if (bus.csr_we_o !== 1'b0) begin bad++; $display("FAIL %s csr_we_in_redirect got=%0b exp=0", nm, bus.csr_we_o); end
         if (!e.is_mret) begin
            total++; if (bus.mcause_o !== e.cause) begin bad++; $display("FAIL %s mcause_hold got=%08h exp=%08h", nm, bus.mcause_o, e.cause); end
         end
         @(posedge clk); #1;
         bus.redirect_ack_i = 1'b0;
      end
      $display("xact %s cause=%08h epc=%08h target=%08h state=%b", nm, e.cause, e.epc, e.target, e.st);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.sw_irq_i = 1'b1; bus.tim_irq_i = 1'b1; bus.ext_irq_i = 1'b1; bus.local_irq_i = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (bus.mip_o !== 32'h0) begin bad++; $display("FAIL reset mip got=%08h exp=0", bus.mip_o); end
      total++; if ({bus.flush_req_o, bus.csr_we_o, bus.trap_valid_o, bus.busy_o} !== 4'b0) begin bad++; $display("FAIL reset strobes got=%b exp=0000", {bus.flush_req_o, bus.csr_we_o, bus.trap_valid_o, bus.busy_o}); end
      total++; if ({bus.mcause_o, bus.mepc_o, bus.mtval_o, bus.trap_address_o, bus.trap_state_o} !== '0) begin bad++; $display("FAIL reset csr_outputs got=%08h/%08h/%08h/%08h exp=0", bus.mcause_o, bus.mepc_o, bus.mtval_o, bus.trap_address_o); end
      bus.sw_irq_i = 1'b0; bus.tim_irq_i = 1'b0; bus.ext_irq_i = 1'b0; bus.local_irq_i = '0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      $display("xact reset done");
   endtask

   task automatic test_mip();
      logic [31:0] prev, now;
      bus.mstatus_mie_i = 1'b0;
      bus.mie_i = '1;
      prev = '0;
      for (int n = 0; n < 16; n++) begin
         bus.sw_irq_i = 1'($urandom); bus.tim_irq_i = 1'($urandom);
         bus.ext_irq_i = 1'($urandom); bus.local_irq_i = NL'($urandom);
         now = exp_mip(bus.sw_irq_i, bus.tim_irq_i, bus.ext_irq_i, bus.local_irq_i);
         @(negedge clk);
         total++; if (bus.mip_o !== prev) begin bad++; $display("FAIL mip n=%0d got=%08h exp=%08h", n, bus.mip_o, prev); end
         prev = now;
         @(posedge clk); #1;
      end
      bus.sw_irq_i = 1'b0; bus.tim_irq_i = 1'b0; bus.ext_irq_i = 1'b0; bus.local_irq_i = '0;
      bus.mie_i = '0;
      @(posedge clk); #1;
      $display("xact mip tracking done");
   endtask

   task automatic test_illegal();
      trap_t e;
      bus.priv_lvl_i = 1'b1; bus.mstatus_mie_i = 1'b1; bus.mtvec_i = 32'h201;
      bus.fault_pc_i = 32'h100; bus.fault_instr_i = 32'hFFFF_FFFF;
      bus.instr_exc_i = 2'b10;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'd2, epc: 32'h100, tval: 32'hFFFF_FFFF, target: 32'h200, st: 3'b011};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "illegal");
   endtask

   task automatic test_ext_irq();
      trap_t e;
      bus.mstatus_mie_i = 1'b0; bus.ext_irq_i = 1'b1; bus.mie_i = 32'h800; bus.mtvec_i = 32'h201;
      @(posedge clk); #1;
      bus.mstatus_mie_i = 1'b1; bus.next_pc_i = 32'h44; bus.priv_lvl_i = 1'b1;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_000B, epc: 32'h44, tval: 32'h0, target: 32'h22C, st: 3'b011};
      take_and_check(e, 2, 1, 1'b0, 1'b0, "ext_irq");
      bus.mstatus_mie_i = 1'b0; bus.ext_irq_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_irq_priority();
      trap_t e;
      bus.mstatus_mie_i = 1'b0; bus.tim_irq_i = 1'b1; bus.local_irq_i = NL'(1 << 2);
      bus.mie_i = (32'h1 << 7) | (32'h1 << 18); bus.mtvec_i = 32'h401; bus.priv_lvl_i = 1'b0;
      @(posedge clk); #1;
      bus.mstatus_mie_i = 1'b1; bus.next_pc_i = 32'h50;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_0007, epc: 32'h50, tval: 32'h0, target: 32'h41C, st: 3'b010};
      take_and_check(e, 1, 2, 1'b0, 1'b0, "tim_over_local");
      bus.mstatus_mie_i = 1'b0; bus.tim_irq_i = 1'b0;
      @(posedge clk); #1;
      bus.mstatus_mie_i = 1'b1; bus.next_pc_i = 32'h54;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_0012, epc: 32'h54, tval: 32'h0, target: 32'h448, st: 3'b010};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "local2");
      bus.mstatus_mie_i = 1'b0; bus.local_irq_i = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_exc_vs_irq();
      trap_t e;
      bus.mstatus_mie_i = 1'b0; bus.ext_irq_i = 1'b1; bus.mie_i = 32'h800;
      bus.mtvec_i = 32'h201; bus.priv_lvl_i = 1'b1;
      @(posedge clk); #1;
      bus.mstatus_mie_i = 1'b1; bus.lsu_exc_i = 2'b01; bus.fault_addr_i = 32'h1003;
      bus.fault_pc_i = 32'h120; bus.next_pc_i = 32'h124;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'd4, epc: 32'h120, tval: 32'h1003, target: 32'h200, st: 3'b011};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "load_mis_over_ext");
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_000B, epc: 32'h124, tval: 32'h0, target: 32'h22C, st: 3'b011};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "ext_after_return");
      bus.mstatus_mie_i = 1'b0; bus.ext_irq_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mret_slow_flush();
      trap_t e;
      bus.mstatus_mie_i = 1'b0; bus.mret_i = 1'b1; bus.mepc_i = 32'h80; bus.mstatus_mpie_i = 1'b1;
      e = '{is_mret: 1'b1, take: 1'b1, cause: 32'h0, epc: 32'h0, tval: 32'h0, target: 32'h80, st: 3'b110};
      take_and_check(e, 3, 1, 1'b0, 1'b0, "mret_slow_flush");
   endtask

   task automatic test_back_to_back();
      trap_t e;
      bus.mstatus_mie_i = 1'b0; bus.sw_irq_i = 1'b1; bus.mie_i = 32'h8;
      bus.mtvec_i = 32'h800; bus.priv_lvl_i = 1'b1; bus.next_pc_i = 32'h900;
      @(posedge clk); #1;
      bus.mstatus_mie_i = 1'b1;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_0003, epc: 32'h900, tval: 32'h0, target: 32'h800, st: 3'b011};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "b2b_first");
      take_and_check(e, 1, 1, 1'b0, 1'b0, "b2b_second");
      bus.mstatus_mie_i = 1'b0; bus.sw_irq_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      trap_t e;
      for (int n = 0; n < 40; n++) begin
         clear_exc();
         bus.mstatus_mie_i = 1'b0;
         bus.sw_irq_i = 1'($urandom); bus.tim_irq_i = 1'($urandom);
         bus.ext_irq_i = 1'($urandom); bus.local_irq_i = NL'($urandom);
         @(posedge clk); #1;
         bus.instr_exc_i   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         bus.lsu_exc_i     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         bus.ecall_i       = ($urandom_range(0, 4) == 0);
         bus.mret_i        = ($urandom_range(0, 4) == 0);
         bus.mstatus_mie_i = 1'($urandom); bus.mstatus_mpie_i = 1'($urandom);
         bus.priv_lvl_i    = 1'($urandom);
         bus.mie_i = $urandom; bus.mtvec_i = $urandom; bus.mepc_i = $urandom;
         bus.fault_pc_i = $urandom; bus.next_pc_i = $urandom;
         bus.fault_instr_i = $urandom; bus.fault_addr_i = $urandom;
         e = model_take();
         if (e.take) begin
            take_and_check(e, $urandom_range(1, 3), $urandom_range(1, 3), 1'b1, 1'b0, $sformatf("rand%0d", n));
         end else begin
            @(posedge clk); #1;
            clear_exc();
            bus.mstatus_mie_i = 1'b0;
            @(negedge clk);
            total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rand%0d no_take busy=%0b exp=0", n, bus.busy_o); end
            $display("xact rand%0d no trap", n);
            @(posedge clk); #1;
         end
      end
      clear_exc();
      bus.mstatus_mie_i = 1'b0;
      bus.sw_irq_i = 1'b0; bus.tim_irq_i = 1'b0; bus.ext_irq_i = 1'b0; bus.local_irq_i = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bus.mstatus_mie_i = 1'b0; bus.instr_exc_i = 2'b10;
      bus.fault_pc_i = 32'h300; bus.fault_instr_i = 32'h1234; bus.mtvec_i = 32'h600;
      @(posedge clk); #1;
      clear_exc();
      bus.flush_ack_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_ack_i = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL reset_mid in_update busy=%0b exp=1", bus.busy_o); end
      total++; if (bus.csr_we_o !== 1'b0) begin bad++; $display("FAIL reset_mid csr_we got=%0b exp=0", bus.csr_we_o); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if ({bus.flush_req_o, bus.csr_we_o, bus.trap_valid_o, bus.busy_o} !== 4'b0) begin bad++; $display("FAIL reset_mid strobes got=%b exp=0000", {bus.flush_req_o, bus.csr_we_o, bus.trap_valid_o, bus.busy_o}); end
      total++; if ({bus.mcause_o, bus.mepc_o, bus.mtval_o, bus.trap_address_o, bus.trap_state_o, bus.mip_o} !== '0) begin bad++; $display("FAIL reset_mid csr_outputs got=%08h/%08h/%08h/%08h exp=0", bus.mcause_o, bus.mepc_o, bus.mtval_o, bus.trap_address_o); end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      $display("xact reset mid-sequence done");
   endtask

`ifdef BETA_TCU_NMI_EN
   task automatic test_nmi();
      trap_t e;
      bus.mstatus_mie_i = 1'b0; bus.priv_lvl_i = 1'b1; bus.mtvec_i = 32'h201;
      bus.instr_exc_i = 2'b10; bus.fault_pc_i = 32'h200; bus.next_pc_i = 32'h204;
      nmi = 1'b1;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_0000, epc: 32'h204, tval: 32'h0, target: NMI_VEC, st: 3'b001};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "nmi_over_illegal");
      bus.instr_exc_i = 2'b10; bus.fault_pc_i = 32'h240; bus.fault_instr_i = 32'h77; bus.next_pc_i = 32'h244;
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'd2, epc: 32'h240, tval: 32'h77, target: 32'h200, st: 3'b001};
      take_and_check(e, 2, 1, 1'b0, 1'b1, "illegal_nmi_in_busy");
      e = '{is_mret: 1'b0, take: 1'b1, cause: 32'h8000_0000, epc: 32'h244, tval: 32'h0, target: NMI_VEC, st: 3'b001};
      take_and_check(e, 1, 1, 1'b0, 1'b0, "held_nmi");
      @(negedge clk);
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL nmi_cleared busy=%0b exp=0", bus.busy_o); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      bus.priv_lvl_i = 1'b0; bus.fault_pc_i = '0; bus.next_pc_i = '0;
      bus.fault_instr_i = '0; bus.fault_addr_i = '0;
      bus.instr_exc_i = '0; bus.lsu_exc_i = '0; bus.ecall_i = 1'b0; bus.mret_i = 1'b0;
      bus.mstatus_mie_i = 1'b0; bus.mstatus_mpie_i = 1'b0;
      bus.mie_i = '0; bus.mtvec_i = '0; bus.mepc_i = '0;
      bus.sw_irq_i = 1'b0; bus.tim_irq_i = 1'b0; bus.ext_irq_i = 1'b0; bus.local_irq_i = '0;
      bus.flush_ack_i = 1'b0; bus.redirect_ack_i = 1'b0;
      test_reset();
      test_mip();
      test_illegal();
      test_ext_irq();
      test_irq_priority();
      test_exc_vs_irq();
      test_mret_slow_flush();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef BETA_TCU_NMI_EN
      test_nmi();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
